// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit_pkg
// Purpose  : Shared MDUControl operation codes, FSM state type and the
//            64-bit multiply/divide result function for mult_div_unit.
// Revision : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

   // MDUControl operation codes; unlisted codes behave as NOP
   localparam logic [3:0] MDU_NOP   = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MTHI  = 4'd5;
   localparam logic [3:0] MDU_MTLO  = 4'd6;
   localparam logic [3:0] MDU_MFHI  = 4'd7;
   localparam logic [3:0] MDU_MFLO  = 4'd8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_t;

   // Returns {HI, LO} for a multiply/divide op. Divide-by-zero and the
   // signed overflow case are resolved explicitly so the divider never
   // sees them (and the result is architecturally defined).
   function automatic logic [63:0] mdu_compute(input logic [3:0]  op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
      logic signed [63:0] sprod;
      logic [63:0]        uprod;
      logic signed [31:0] squot;
      logic signed [31:0] srem;
      logic [63:0]        res;
      sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      uprod = {32'd0, a} * {32'd0, b};
      squot = '0;
      srem  = '0;
      res   = '0;
      case (op)
         MDU_MULT:  res = sprod;
         MDU_MULTU: res = uprod;
         MDU_DIV: begin
            if (b == 32'd0) begin
               res = {a, 32'hFFFF_FFFF};
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               res = {32'h0000_0000, 32'h8000_0000};
            end else begin
               // SystemVerilog truncates toward zero; remainder takes the
               // dividend's sign
               squot = $signed(a) / $signed(b);
               srem  = $signed(a) % $signed(b);
               res   = {srem, squot};
            end
         end
         MDU_DIVU: begin
            if (b == 32'd0) begin
               res = {a, 32'hFFFF_FFFF};
            end else begin
               res = {a % b, a / b};
            end
         end
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : EX-stage multi-cycle multiply/divide unit owning HI/LO. Results
//            are computed at Start, held in pending registers and committed
//            after a fixed latency while Busy stalls dependent instructions.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [3:0]  MDUControl,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUResult
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   mdu_state_t       state, state_next;
   logic [CNT_W-1:0] count, count_next;
   logic [31:0]      pend_hi, pend_hi_next;
   logic [31:0]      pend_lo, pend_lo_next;
   logic [31:0]      hi_next, lo_next;
   logic [63:0]      op_result;
   logic             is_start_op;
   logic             is_mult_op;

   assign is_start_op = (MDUControl >= MDU_MULT) && (MDUControl <= MDU_DIVU);
   assign is_mult_op  = (MDUControl == MDU_MULT) || (MDUControl == MDU_MULTU);
   assign op_result   = mdu_compute(MDUControl, SrcA, SrcB);

   // The counter is loaded with N and the commit happens on the edge where it
   // would step from 1 to 0, giving exactly N Busy cycles after the Start edge.
   // Next-state, counter, pending and HI/LO write selection
   always_comb begin
      state_next   = state;
      count_next   = count;
      pend_hi_next = pend_hi;
      pend_lo_next = pend_lo;
      hi_next      = HI;
      lo_next      = LO;
      case (state)
         ST_IDLE: begin
            if (Start && is_start_op) begin
               state_next                   = ST_RUN;
               count_next                   = is_mult_op ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
               {pend_hi_next, pend_lo_next} = op_result;
            end
            if (MDUControl == MDU_MTHI) begin
               hi_next = SrcA;
            end
            if (MDUControl == MDU_MTLO) begin
               lo_next = SrcA;
            end
         end
         ST_RUN: begin
            if (count <= CNT_W'(1)) begin
               state_next = ST_IDLE;
               count_next = '0;
               hi_next    = pend_hi;
               lo_next    = pend_lo;
            end else begin
               count_next = count - CNT_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State, counter, pending result and architectural HI/LO registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         count   <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         HI      <= '0;
         LO      <= '0;
      end else begin
         state   <= state_next;
         count   <= count_next;
         pend_hi <= pend_hi_next;
         pend_lo <= pend_lo_next;
         HI      <= hi_next;
         LO      <= lo_next;
      end
   end

   assign Busy = (state == ST_RUN);

   // mfhi/mflo read the committed registers directly
   always_comb begin
      MDUResult = '0;
      case (MDUControl)
         MDU_MFHI: MDUResult = HI;
         MDU_MFLO: MDUResult = LO;
         default:  MDUResult = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit in the EX stage, beside the ALU. It takes the same forwarded SrcA/SrcB operands and owns the architectural HI/LO registers. It executes mult, multu, div, divu, mthi, mtlo with fixed latencies and serves mfhi/mflo reads. It drives Busy so the hazard unit can stall later multiply/divide instructions.

## Interface
Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu
- DIV_CYCLES, 10, Busy cycles for div/divu

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- Start  in  1  EX-stage instruction is mult/multu/div/divu; one-cycle pulse
- MDUControl  in  4  operation code (shared header)
- SrcA  in  32  forwarded rs value
- SrcB  in  32  forwarded rt value
- Busy  out  1  registered; operation in flight
- HI  out  32  architectural HI register
- LO  out  32  architectural LO register
- MDUResult  out  32  combinational: HI for mfhi, LO for mflo, else 0

## Operation
MDUControl codes:
- NOP = 0
- MULT = 1, MULTU = 2, DIV = 3, DIVU = 4
- MTHI = 5, MTLO = 6
- MFHI = 7, MFLO = 8

Unused codes act as NOP.

Start of an operation:
- Start is honoured only when Busy = 0 and the code is MULT..DIVU.
- The 64-bit result is computed from SrcA/SrcB sampled on the Start edge.
- The result goes into pending registers, not HI/LO.
- A down-counter loads MULT_CYCLES or DIV_CYCLES.

Operation results:
- MULT: {HI,LO} = $signed(SrcA) * $signed(SrcB), full 64 bits.
- MULTU: unsigned product.
- DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
- DIVU: unsigned quotient/remainder.
- Divide by zero (either variant): LO = 32'hFFFF_FFFF, HI = SrcA.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0.

Commit and writes:
- Completion: when the counter reaches 0, pending HI/LO commit to HI/LO on that edge and Busy falls.
- MTHI/MTLO: write SrcA to HI/LO on the edge, with no Busy, only when Busy = 0.
- Start, MTHI or MTLO while Busy = 1 is ignored. The hazard unit guarantees this by stalling.
- MFHI/MFLO read the committed HI/LO combinationally. A read while Busy = 1 returns the old value; the hazard unit stalls these reads.

States:
- IDLE (Busy = 0), on valid Start -> RUN
- RUN (Busy = 1), counter decrements each cycle; at 0 -> commit -> IDLE

## Timing
- Reset: HI = 0, LO = 0, Busy = 0, counter = 0, pending = 0, state IDLE. Reset during RUN aborts with no commit.
- Start sampled at edge E0:
  - Busy = 1 for exactly N cycles after E0 (N = MULT_CYCLES or DIV_CYCLES).
  - HI/LO take the new value and Busy = 0 at edge E0+N.
- Back-to-back: a Start in the same cycle Busy is first seen low is accepted. The throughput is one operation per N+1 cycles.
- MTHI/MTLO writes are visible on HI/LO and MDUResult the cycle after the edge.
- Start and reset in the same cycle: reset wins.

## Structure
- Shared definitions header: MDUControl code constants (MDU_NOP … MDU_MFLO), next to the ALUControl constants.
- No sub-module. The FSM, counter, pending registers and HI/LO fit in one module.
- The 64-bit product and divide use `*`, `/`, `%`. The multi-cycle latency models pipeline timing, not iterative hardware.

## Test plan
- Reset then MFLO -> MDUResult = 0, Busy = 0.
- MULT SrcA = 32'hFFFF_FFFE (−2), SrcB = 3 -> Busy high 5 cycles, then HI = 32'hFFFF_FFFF, LO = 32'hFFFF_FFFA. HI/LO stay unchanged during Busy.
- DIV SrcA = −7 (32'hFFFF_FFF9), SrcB = 2 -> after 10 cycles LO = 32'hFFFF_FFFD, HI = 32'hFFFF_FFFF. DIVU with the same operands -> LO = 32'h7FFF_FFFC, HI = 1.
- DIVU SrcA = 32'h1234, SrcB = 0 -> LO = 32'hFFFF_FFFF, HI = 32'h1234. DIV 32'h8000_0000 / −1 -> LO = 32'h8000_0000, HI = 0.
- MULTU in flight plus MTHI 32'hAAAA on the 2nd Busy cycle -> MTHI ignored; HI = the product high word.
- MULT started, reset on the 3rd Busy cycle -> HI = LO = 0, Busy = 0 next cycle, no later commit.
